// File: rtl/game_cfg_pkg.sv
// Shared types, default menu constants and the try-budget formula for the
// game configuration menu.
package game_cfg_pkg;

    typedef enum logic [1:0] {SELECT, INIT, START, PLAY} state_t;

    localparam int DEF_SIZE_MIN         = 2;
    localparam int DEF_SIZE_STEP        = 4;
    localparam int DEF_SIZE_COUNT       = 7;
    localparam int DEF_SIZE_DEFAULT_IDX = 3;
    localparam int DEF_COLOR_MIN        = 3;
    localparam int DEF_COLOR_MAX        = 8;
    localparam int DEF_COLOR_DEFAULT    = 6;

    // Unsaturated budget; the caller clamps it to its own counter width.
    function automatic logic [15:0] tries_budget(input logic [4:0] size,
                                                 input logic [3:0] colours,
                                                 input int num,
                                                 input int shift);
        logic [15:0] prod;
        prod = 16'(size) * (16'(colours) - 16'd1) * 16'(num);
        return (prod >> shift) + 16'd1;
    endfunction

endpackage

// File: rtl/game_config_menu_button_edge.sv
// Button front end: two-flop synchroniser, registered rising-edge pulse and
// optional auto-repeat while the button stays held.
module button_edge #(
    parameter int REPEAT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    logic sync1_reg, sync2_reg, prev_reg, pulse_reg;
    logic rise, repeat_fire;

    assign rise  = sync2_reg & ~prev_reg;
    assign pulse = pulse_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            pulse_reg <= rise | repeat_fire;
        end
    end

    generate
        if (REPEAT_CYCLES > 0) begin : g_repeat
            localparam int CW = $clog2(REPEAT_CYCLES + 1);
            logic [CW-1:0] cnt_reg;

            // cnt_reg counts cycles since the last step; it fires on reaching the period.
            assign repeat_fire = sync2_reg & prev_reg & (cnt_reg == CW'(REPEAT_CYCLES));

            always_ff @(posedge clk) begin
                if (!rst_n || !sync2_reg) begin
                    cnt_reg <= '0;
                end else if (rise || repeat_fire) begin
                    cnt_reg <= CW'(1);
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end else begin : g_no_repeat
            assign repeat_fire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/game_config_menu.sv
// Board size / colour count menu with computed try budget, board-init and
// begin-game handshakes, and try counting during play.
module game_config_menu
    import game_cfg_pkg::*;
#(
    parameter int SIZE_MIN         = DEF_SIZE_MIN,
    parameter int SIZE_STEP        = DEF_SIZE_STEP,
    parameter int SIZE_COUNT       = DEF_SIZE_COUNT,
    parameter int SIZE_DEFAULT_IDX = DEF_SIZE_DEFAULT_IDX,
    parameter int COLOR_MIN        = DEF_COLOR_MIN,
    parameter int COLOR_MAX        = DEF_COLOR_MAX,
    parameter int COLOR_DEFAULT    = DEF_COLOR_DEFAULT,
    parameter int TRIES_NUM        = 11,
    parameter int TRIES_SHIFT      = 5,
    parameter int REPEAT_CYCLES    = 25000000,
    parameter int TRIES_W          = 8
) (
    input  logic               MASTER_CLOCK,
    input  logic               RESET_N,
    input  logic               UP,
    input  logic               DOWN,
    input  logic               LEFT,
    input  logic               RIGHT,
    input  logic               CENTER,
    input  logic               BOARD_READY,
    input  logic               ACK_BEGIN_GAME,
    input  logic               MOVE_DONE,
    input  logic               GAME_DONE,
    output logic               INITIALIZE_BOARD,
    output logic               BEGIN_GAME,
    output logic [4:0]         SIZE,
    output logic [3:0]         COLOR_NUM,
    output logic [4:0]         final_SIZE,
    output logic [3:0]         final_COLOR_NUM,
    output logic               FIELD_SEL,
    output logic               MODE,
    output logic [TRIES_W-1:0] TRIES,
    output logic [TRIES_W-1:0] TOTAL_TRIES,
    output logic               OUT_OF_TRIES
);
    localparam int IDX_W = (SIZE_COUNT > 1) ? $clog2(SIZE_COUNT) : 1;
    localparam logic [15:0] TRIES_MAX = 16'((1 << TRIES_W) - 1);
    localparam logic [IDX_W-1:0] IDX_RST = IDX_W'(SIZE_DEFAULT_IDX);

    function automatic logic [4:0] size_of(input logic [IDX_W-1:0] idx);
        return 5'(SIZE_MIN + int'(idx) * SIZE_STEP);
    endfunction

    function automatic logic [TRIES_W-1:0] saturate(input logic [15:0] b);
        return (b > TRIES_MAX) ? TRIES_W'(TRIES_MAX) : TRIES_W'(b);
    endfunction

    // step bits: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 CENTER; only UP/DOWN repeat.
    logic [4:0] btn_raw, step;
    assign btn_raw = {CENTER, RIGHT, LEFT, DOWN, UP};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_btn
            button_edge #(
                .REPEAT_CYCLES(gi < 2 ? REPEAT_CYCLES : 0)
            ) u_btn (
                .clk  (MASTER_CLOCK),
                .rst_n(RESET_N),
                .btn  (btn_raw[gi]),
                .pulse(step[gi])
            );
        end
    endgenerate

    state_t             state_reg, state_next;
    logic               field_reg, field_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [3:0]         colour_reg, colour_next;
    logic [4:0]         final_size_reg, final_size_next;
    logic [3:0]         final_colour_reg, final_colour_next;
    logic [TRIES_W-1:0] tries_reg, tries_next, total_reg, total_next;
    logic               out_reg, out_next;

    always_comb begin
        state_next        = state_reg;
        field_next        = field_reg;
        idx_next          = idx_reg;
        colour_next       = colour_reg;
        final_size_next   = final_size_reg;
        final_colour_next = final_colour_reg;
        tries_next        = tries_reg;
        total_next        = total_reg;
        case (state_reg)
            SELECT: begin
                // A start pulse takes priority over any step in the same cycle.
                if (step[3] || step[4]) begin
                    final_size_next   = size_of(idx_reg);
                    final_colour_next = colour_reg;
                    total_next        = saturate(tries_budget(size_of(idx_reg), colour_reg,
                                                              TRIES_NUM, TRIES_SHIFT));
                    tries_next        = '0;
                    state_next        = INIT;
                end else begin
                    if (step[2]) field_next = ~field_reg;
                    if (step[0] && !step[1]) begin
                        if (field_reg) idx_next = (idx_reg == IDX_W'(SIZE_COUNT - 1)) ? '0 : idx_reg + IDX_W'(1);
                        else colour_next = (colour_reg == 4'(COLOR_MAX)) ? 4'(COLOR_MIN) : colour_reg + 4'd1;
                    end else if (step[1] && !step[0]) begin
                        if (field_reg) idx_next = (idx_reg == '0) ? IDX_W'(SIZE_COUNT - 1) : idx_reg - IDX_W'(1);
                        else colour_next = (colour_reg == 4'(COLOR_MIN)) ? 4'(COLOR_MAX) : colour_reg - 4'd1;
                    end
                end
            end
            INIT:  if (BOARD_READY) state_next = START;
            START: if (ACK_BEGIN_GAME) state_next = PLAY;
            PLAY: begin
                if (MOVE_DONE && (tries_reg < total_reg)) tries_next = tries_reg + TRIES_W'(1);
                if (GAME_DONE || step[4]) state_next = SELECT;
            end
            default: state_next = SELECT;
        endcase
        out_next = (state_next == PLAY) && (tries_next == total_reg);
    end

    always_ff @(posedge MASTER_CLOCK) begin
        if (!RESET_N) begin
            state_reg        <= SELECT;
            field_reg        <= 1'b0;
            idx_reg          <= IDX_RST;
            colour_reg       <= 4'(COLOR_DEFAULT);
            final_size_reg   <= size_of(IDX_RST);
            final_colour_reg <= 4'(COLOR_DEFAULT);
            tries_reg        <= '0;
            total_reg        <= saturate(tries_budget(size_of(IDX_RST), 4'(COLOR_DEFAULT),
                                                      TRIES_NUM, TRIES_SHIFT));
            out_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            field_reg        <= field_next;
            idx_reg          <= idx_next;
            colour_reg       <= colour_next;
            final_size_reg   <= final_size_next;
            final_colour_reg <= final_colour_next;
            tries_reg        <= tries_next;
            total_reg        <= total_next;
            out_reg          <= out_next;
        end
    end

    assign INITIALIZE_BOARD = (state_reg == INIT);
    assign BEGIN_GAME       = (state_reg == START);
    assign MODE             = (state_reg == PLAY);
    assign SIZE             = size_of(idx_reg);
    assign COLOR_NUM        = colour_reg;
    assign final_SIZE       = final_size_reg;
    assign final_COLOR_NUM  = final_colour_reg;
    assign FIELD_SEL        = field_reg;
    assign TRIES            = tries_reg;
    assign TOTAL_TRIES      = total_reg;
    assign OUT_OF_TRIES     = out_reg;

endmodule

// File: tb/tb_game_config_menu.sv
// Randomised bench for game_config_menu against an arithmetic menu/game model.
module tb_game_config_menu;
    localparam int R = 10;

    logic MASTER_CLOCK = 1'b0;
    logic RESET_N = 1'b0;
    logic UP = 1'b0, DOWN = 1'b0, LEFT = 1'b0, RIGHT = 1'b0, CENTER = 1'b0;
    logic BOARD_READY = 1'b0, ACK_BEGIN_GAME = 1'b0, MOVE_DONE = 1'b0, GAME_DONE = 1'b0;
    logic INITIALIZE_BOARD, BEGIN_GAME, FIELD_SEL, MODE, OUT_OF_TRIES;
    logic [4:0] SIZE, final_SIZE;
    logic [3:0] COLOR_NUM, final_COLOR_NUM;
    logic [7:0] TRIES, TOTAL_TRIES;

    int checks = 0;
    int errors = 0;
    int txn = 0;
    // Model: state 0 select, 1 init, 2 start, 3 play.
    int m_idx, m_col, m_field, m_state, m_fsize, m_fcol, m_tries, m_total;

    game_config_menu #(.REPEAT_CYCLES(R)) dut (
        .MASTER_CLOCK(MASTER_CLOCK), .RESET_N(RESET_N),
        .UP(UP), .DOWN(DOWN), .LEFT(LEFT), .RIGHT(RIGHT), .CENTER(CENTER),
        .BOARD_READY(BOARD_READY), .ACK_BEGIN_GAME(ACK_BEGIN_GAME),
        .MOVE_DONE(MOVE_DONE), .GAME_DONE(GAME_DONE),
        .INITIALIZE_BOARD(INITIALIZE_BOARD), .BEGIN_GAME(BEGIN_GAME),
        .SIZE(SIZE), .COLOR_NUM(COLOR_NUM), .final_SIZE(final_SIZE),
        .final_COLOR_NUM(final_COLOR_NUM), .FIELD_SEL(FIELD_SEL), .MODE(MODE),
        .TRIES(TRIES), .TOTAL_TRIES(TOTAL_TRIES), .OUT_OF_TRIES(OUT_OF_TRIES)
    );

    always #5 MASTER_CLOCK = ~MASTER_CLOCK;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge MASTER_CLOCK);
        #1;
    endtask

    function automatic int size_of(input int idx);
        return 2 + 4 * idx;
    endfunction

    function automatic int budget(input int s, input int c);
        int b;
        b = ((s * (c - 1) * 11) >> 5) + 1;
        return (b > 255) ? 255 : b;
    endfunction

    task automatic model_reset();
        m_idx = 3; m_col = 6; m_field = 0; m_state = 0;
        m_fsize = 14; m_fcol = 6; m_tries = 0; m_total = budget(14, 6);
    endtask

    task automatic model_step(input int n);
        if (m_field != 0) m_idx = ((m_idx + n) % 7 + 7) % 7;
        else m_col = 3 + ((m_col - 3 + n) % 6 + 6) % 6;
    endtask

    task automatic check_all();
        check_eq("size", int'(SIZE), size_of(m_idx));
        check_eq("colour", int'(COLOR_NUM), m_col);
        check_eq("field_sel", int'(FIELD_SEL), m_field);
        check_eq("mode", int'(MODE), int'(m_state == 3));
        check_eq("init_board", int'(INITIALIZE_BOARD), int'(m_state == 1));
        check_eq("begin_game", int'(BEGIN_GAME), int'(m_state == 2));
        check_eq("final_size", int'(final_SIZE), m_fsize);
        check_eq("final_colour", int'(final_COLOR_NUM), m_fcol);
        check_eq("tries", int'(TRIES), m_tries);
        check_eq("total_tries", int'(TOTAL_TRIES), m_total);
        check_eq("out_of_tries", int'(OUT_OF_TRIES), int'(m_state == 3 && m_tries == m_total));
    endtask

    // mask bits: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 CENTER
    task automatic press(input logic [4:0] mask, input int hold);
        int n;
        {CENTER, RIGHT, LEFT, DOWN, UP} = mask;
        repeat (hold) tick();
        {CENTER, RIGHT, LEFT, DOWN, UP} = 5'b0;
        repeat (8) tick();
        n = 1 + (hold - 1) / R;
        if (m_state == 0) begin
            if (mask[3] || mask[4]) begin
                m_fsize = size_of(m_idx);
                m_fcol = m_col;
                m_total = budget(m_fsize, m_col);
                m_tries = 0;
                m_state = 1;
            end else begin
                if (mask[2]) m_field = 1 - m_field;
                if (mask[0] && !mask[1]) model_step(n);
                else if (mask[1] && !mask[0]) model_step(-n);
            end
        end else if (m_state == 3 && mask[4]) begin
            m_state = 0;
        end
        txn++;
        $display("txn %0d press mask=%b hold=%0d -> size=%0d colour=%0d field=%0d mode=%0d",
                 txn, mask, hold, SIZE, COLOR_NUM, FIELD_SEL, MODE);
        check_all();
    endtask

    task automatic go_to(input int idx, input int col);
        if (m_field == 0) press(5'b00100, 1);
        while (m_idx != idx) press(5'b00001, 1);
        press(5'b00100, 1);
        while (m_col != col) press(5'b00001, 1);
    endtask

    // exit_kind: 0 GAME_DONE, 1 CENTER, 2 MOVE_DONE together with GAME_DONE
    task automatic play_game(input logic [4:0] start_mask, input int moves, input int exit_kind);
        press(start_mask, 1);
        ACK_BEGIN_GAME = 1'b1; tick(); ACK_BEGIN_GAME = 1'b0;
        check_all();
        BOARD_READY = 1'b1; tick(); BOARD_READY = 1'b0;
        m_state = 2;
        check_all();
        ACK_BEGIN_GAME = 1'b1; tick(); ACK_BEGIN_GAME = 1'b0;
        m_state = 3;
        check_all();
        BOARD_READY = 1'b1; tick(); BOARD_READY = 1'b0;
        check_all();
        for (int i = 0; i < moves; i++) begin
            MOVE_DONE = 1'b1; tick(); MOVE_DONE = 1'b0;
            if (m_tries < m_total) m_tries++;
            check_all();
        end
        if (exit_kind == 1) begin
            press(5'b10000, 1);
        end else begin
            GAME_DONE = 1'b1;
            MOVE_DONE = (exit_kind == 2);
            tick();
            GAME_DONE = 1'b0;
            MOVE_DONE = 1'b0;
            if (exit_kind == 2 && m_tries < m_total) m_tries++;
            m_state = 0;
            check_all();
        end
        txn++;
        $display("txn %0d game size=%0d colour=%0d moves=%0d exit=%0d -> tries=%0d/%0d",
                 txn, final_SIZE, final_COLOR_NUM, moves, exit_kind, TRIES, TOTAL_TRIES);
    endtask

    initial begin
        int exp_col[3];
        int exp_size[4];
        logic [4:0] masks[4];
        int pre_col;
        exp_col = '{7, 8, 3};
        exp_size = '{10, 6, 2, 26};
        masks = '{5'b00001, 5'b00010, 5'b00100, 5'b00011};

        // Reset state
        RESET_N = 1'b0;
        repeat (2) tick();
        RESET_N = 1'b1;
        tick();
        model_reset();
        check_eq("reset_size", int'(SIZE), 14);
        check_eq("reset_colour", int'(COLOR_NUM), 6);
        check_eq("reset_total", int'(TOTAL_TRIES), 25);
        check_all();

        // Wrap in both fields
        for (int i = 0; i < 3; i++) begin
            press(5'b00001, 1);
            check_eq("wrap_colour", int'(COLOR_NUM), exp_col[i]);
        end
        press(5'b00100, 1);
        for (int i = 0; i < 4; i++) begin
            press(5'b00010, 1);
            check_eq("wrap_size", int'(SIZE), exp_size[i]);
        end

        // Auto-repeat: 35 held cycles at period 10 give four steps (3 -> 7)
        press(5'b00100, 1);
        press(5'b00001, 35);
        check_eq("repeat_colour", int'(COLOR_NUM), 7);
        press(5'b00011, 1);
        check_eq("up_down_same", int'(COLOR_NUM), 7);

        // Stray ACK in SELECT
        ACK_BEGIN_GAME = 1'b1; tick(); ACK_BEGIN_GAME = 1'b0; tick();
        check_all();

        // Handshake at the largest configuration
        go_to(6, 8);
        play_game(5'b01000, 0, 0);
        check_eq("hs_total", int'(TOTAL_TRIES), 63);
        check_eq("hs_final_size", int'(final_SIZE), 26);

        // Try saturation with the smallest configuration
        go_to(0, 3);
        play_game(5'b10000, 3, 0);
        check_eq("sat_tries", int'(TRIES), 2);
        check_eq("sat_total", int'(TOTAL_TRIES), 2);

        // Reset while BEGIN_GAME is held
        press(5'b01000, 1);
        BOARD_READY = 1'b1; tick(); BOARD_READY = 1'b0;
        check_eq("pre_reset_begin", int'(BEGIN_GAME), 1);
        RESET_N = 1'b0; tick();
        check_eq("reset_begin", int'(BEGIN_GAME), 0);
        RESET_N = 1'b1; tick();
        model_reset();
        check_all();

        // Start in the same cycle as a step: pre-step colour is latched
        pre_col = m_col;
        play_game(5'b01001, 2, 2);
        check_eq("start_wins", int'(final_COLOR_NUM), pre_col);

        // Random menu activity
        for (int i = 0; i < 30; i++)
            press(masks[$urandom_range(0, 3)], $urandom_range(1, 25));

        // Random games
        for (int g = 0; g < 5; g++) begin
            go_to($urandom_range(0, 6), $urandom_range(3, 8));
            play_game($urandom_range(0, 1) ? 5'b01000 : 5'b10000,
                      $urandom_range(0, 8), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
